// File: rtl/iob_gpio_scan_pkg.sv
// iob_gpio_scan_pkg: shared state encoding and widths for the GPIO scan controller
package iob_gpio_scan_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;
  localparam int DB_CW = 2;
  function automatic int slot_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/iob_gpio_scan_db.sv
// iob_gpio_scan_db: per-key frame-rate debounce counter and debounced state bit
module iob_gpio_scan_db
  import iob_gpio_scan_pkg::*;
#(
  parameter int DB_N = 3
) (
  input  logic clk,
  input  logic arst_n,
  input  logic strobe,
  input  logic sample,
  output logic key,
  output logic chg
);
  logic [DB_CW-1:0] cnt;
  logic hit;
  assign hit = sample != key && cnt + DB_CW'(1) == DB_CW'(DB_N);
  assign chg = strobe && hit;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      cnt <= '0;
      key <= 1'b0;
    end else if (strobe) begin
      cnt <= (sample == key || hit) ? '0 : cnt + DB_CW'(1);
      key <= key ^ hit;
    end
endmodule

// File: rtl/iob_gpio_scan.sv
// iob_gpio_scan: multiplexed display drive and keypad scan over shared scan lines
module iob_gpio_scan
  import iob_gpio_scan_pkg::*;
#(
  parameter int N_DIG   = 4,
  parameter int SEG_W   = 8,
  parameter int RET_W   = 4,
  parameter int DWELL_W = 16,
  parameter int DB_N    = 3
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     en,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic [N_DIG*SEG_W-1:0]   frame_in,
  input  logic                     frame_load,
  input  logic [RET_W-1:0]         ret_in,
  output logic [N_DIG-1:0]         scan_sel,
  output logic [SEG_W-1:0]         seg_out,
  output logic [N_DIG*RET_W-1:0]   key_state,
  output logic                     key_event,
  output logic                     frame_done
);
  localparam int SW = slot_w(N_DIG);
  logic [1:0] state;
  logic [SW-1:0] slot;
  logic [DWELL_W-1:0] cnt, dwell_eff;
  logic [N_DIG*SEG_W-1:0] shadow, active, shadow_nxt;
  logic [N_DIG*RET_W-1:0] sample, chg;
  logic last_slot, frame_end;
  assign shadow_nxt = frame_load ? frame_in : shadow;
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign last_slot = slot == SW'(N_DIG - 1);
  assign frame_end = state == ST_BLANK && last_slot;
  assign scan_sel = (state == ST_DRIVE) ? N_DIG'(1) << slot : '0;
  assign seg_out = (state == ST_DRIVE) ? active[int'(slot)*SEG_W +: SEG_W] : '0;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state      <= ST_IDLE;
      slot       <= '0;
      cnt        <= '0;
      shadow     <= '0;
      active     <= '0;
      sample     <= '0;
      frame_done <= 1'b0;
      key_event  <= 1'b0;
    end else begin
      shadow     <= shadow_nxt;
      frame_done <= frame_end;
      key_event  <= |chg;
      if (!en) begin
        state  <= ST_IDLE;
        slot   <= '0;
        sample <= '0;
      end else if (state == ST_IDLE) begin
        state  <= ST_DRIVE;
        slot   <= '0;
        cnt    <= dwell_eff;
        active <= shadow_nxt;
      end else if (state == ST_DRIVE) begin
        if (cnt == DWELL_W'(1)) begin
          sample[int'(slot)*RET_W +: RET_W] <= ret_in;
          state <= ST_BLANK;
        end else
          cnt <= cnt - DWELL_W'(1);
      end else if (state == ST_BLANK) begin
        state <= ST_DRIVE;
        cnt   <= dwell_eff;
        if (last_slot) begin
          slot   <= '0;
          active <= shadow_nxt;
        end else
          slot <= slot + SW'(1);
      end else
        state <= ST_IDLE;
    end
  for (genvar i = 0; i < N_DIG*RET_W; i++) begin : g_db
    iob_gpio_scan_db #(.DB_N(DB_N)) u_db (
      .clk   (clk),
      .arst_n(arst_n),
      .strobe(frame_end),
      .sample(sample[i]),
      .key   (key_state[i]),
      .chg   (chg[i])
    );
  end
endmodule

// File: tb/tb_iob_gpio_scan.sv
// tb_iob_gpio_scan: directed and randomized checks of the scan controller against a frame-level model
module tb_iob_gpio_scan;
  localparam int N = 4, SW = 8, RW = 4, DW = 16, DB_N = 3;
  logic clk = 0, arst_n = 0, en = 0, frame_load = 0, use_kp = 1;
  logic [DW-1:0] dwell = '0;
  logic [N*SW-1:0] frame_in = '0;
  logic [RW-1:0] ret_in, kp_ret, noise = '0;
  logic [RW-1:0] kp [N];
  logic [N-1:0] scan_sel;
  logic [SW-1:0] seg_out;
  logic [N*RW-1:0] key_state;
  logic key_event, frame_done;
  int errors = 0, checks = 0, shown = 0;
  always #5 clk = ~clk;
  iob_gpio_scan #(.N_DIG(N), .SEG_W(SW), .RET_W(RW), .DWELL_W(DW), .DB_N(DB_N)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .dwell(dwell), .frame_in(frame_in),
    .frame_load(frame_load), .ret_in(ret_in), .scan_sel(scan_sel), .seg_out(seg_out),
    .key_state(key_state), .key_event(key_event), .frame_done(frame_done)
  );
  always_comb begin
    kp_ret = '0;
    for (int r = 0; r < N; r++) if (scan_sel[r]) kp_ret = kp_ret | kp[r];
  end
  assign ret_in = use_kp ? kp_ret : noise;
  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (shown < 40) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      shown++;
    end
  endtask
  bit m_run = 0, m_done = 0, m_event = 0;
  int m_k = 0, m_p = 2, m_pos = 0, e_pos = 0;
  logic [N*SW-1:0] m_shadow = '0, m_active = '0, m_nsh = '0;
  logic [RW-1:0] m_samp [N];
  logic [N*RW-1:0] m_key = '0;
  int m_cnt [N*RW];
  logic [N-1:0] e_sel;
  logic [SW-1:0] e_seg;
  initial forever begin
    @(posedge clk or negedge arst_n);
    if (!arst_n) begin
      m_run = 0; m_k = 0; m_p = 2; m_shadow = '0; m_active = '0; m_key = '0;
      m_done = 0; m_event = 0;
      for (int i = 0; i < N*RW; i++) m_cnt[i] = 0;
      for (int r = 0; r < N; r++) m_samp[r] = '0;
    end else begin
      m_nsh = frame_load ? frame_in : m_shadow;
      m_done = 0;
      m_event = 0;
      if (m_run) begin
        m_pos = m_k % (N*m_p);
        if (m_pos % m_p == m_p - 2) m_samp[m_pos/m_p] = ret_in;
        if (m_pos == N*m_p - 1) begin
          m_done = 1;
          for (int i = 0; i < N*RW; i++) begin
            if (m_samp[i/RW][i%RW] != m_key[i]) begin
              m_cnt[i]++;
              if (m_cnt[i] == DB_N) begin
                m_key[i] = ~m_key[i];
                m_cnt[i] = 0;
                m_event = 1;
              end
            end else m_cnt[i] = 0;
          end
          m_active = m_nsh;
        end
        m_k++;
        m_run = en;
      end else if (en) begin
        m_run = 1;
        m_k = 0;
        m_p = (dwell == 0 ? 1 : int'(dwell)) + 1;
        m_active = m_nsh;
      end
      m_shadow = m_nsh;
    end
  end
  initial forever begin
    @(negedge clk);
    e_sel = '0;
    e_seg = '0;
    if (m_run) begin
      e_pos = m_k % (N*m_p);
      if (e_pos % m_p != m_p - 1) begin
        e_sel[e_pos/m_p] = 1'b1;
        e_seg = m_active[(e_pos/m_p)*SW +: SW];
      end
    end
    cmp("scan_sel", scan_sel, e_sel);
    cmp("seg_out", seg_out, e_seg);
    cmp("key_state", key_state, m_key);
    cmp("key_event", key_event, m_event);
    cmp("frame_done", frame_done, m_done);
  end
  initial begin
    int nd, nev;
    for (int r = 0; r < N; r++) kp[r] = '0;
    repeat (3) @(negedge clk);
    cmp("rst_sel", scan_sel, 0);
    cmp("rst_seg", seg_out, 0);
    cmp("rst_key", key_state, 0);
    cmp("rst_done", frame_done, 0);
    arst_n = 1;
    repeat (2) @(negedge clk);
    cmp("idle_sel", scan_sel, 0);
    dwell = 3; frame_in = 32'h11223344; frame_load = 1;
    @(negedge clk); frame_load = 0;
    @(negedge clk); en = 1;
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (c == 1) begin cmp("a1_sel", scan_sel, 4'b0001); cmp("a1_seg", seg_out, 8'h44); end
      if (c == 4) cmp("a4_blank", scan_sel, 0);
      if (c == 5) begin cmp("a5_sel", scan_sel, 4'b0010); cmp("a5_seg", seg_out, 8'h33); end
      if (c == 9) begin cmp("a9_sel", scan_sel, 4'b0100); cmp("a9_seg", seg_out, 8'h22); end
      if (c == 13) begin cmp("a13_sel", scan_sel, 4'b1000); cmp("a13_seg", seg_out, 8'h11); end
      if (c == 16) cmp("a16_done", frame_done, 0);
      if (c == 17) begin cmp("a17_done", frame_done, 1); cmp("a17_seg", seg_out, 8'hDD); end
      if (c == 21) cmp("a21_seg", seg_out, 8'hCC);
      if (c == 33) begin cmp("a33_done", frame_done, 1); cmp("a33_seg", seg_out, 8'h04); end
      if (c == 42) begin cmp("drop_sel", scan_sel, 0); cmp("drop_seg", seg_out, 0); end
      if (c == 45) begin cmp("reen_sel", scan_sel, 4'b0001); cmp("reen_seg", seg_out, 8'h04); end
      if (c == 6) begin frame_in = 32'hAABBCCDD; frame_load = 1; end
      if (c == 7) frame_load = 0;
      if (c == 32) begin frame_in = 32'h01020304; frame_load = 1; end
      if (c == 33) frame_load = 0;
      if (c == 41) en = 0;
      if (c == 44) en = 1;
    end
    en = 0;
    repeat (3) @(negedge clk);
    dwell = 0; en = 1; nd = 0;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      nd += int'(frame_done);
      if (c == 1) cmp("b1_sel", scan_sel, 4'b0001);
      if (c == 2) cmp("b2_blank", scan_sel, 0);
      if (c == 3) cmp("b3_sel", scan_sel, 4'b0010);
      if (c == 9) cmp("b9_done", frame_done, 1);
    end
    cmp("b_done_count", nd, 2);
    en = 0;
    repeat (3) @(negedge clk);
    dwell = 1; kp[1] = 4'h2; en = 1; nev = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      nev += int'(key_event);
      if (c == 24) cmp("k24_key5", key_state[5], 0);
      if (c == 25) begin cmp("k25_key5", key_state[5], 1); cmp("k25_event", key_event, 1); kp[2] = 4'h8; end
      if (c == 41) kp[2] = 4'h0;
    end
    cmp("k_event_count", nev, 1);
    cmp("k_glitch_key11", key_state[11], 0);
    cmp("k_hold_key5", key_state[5], 1);
    for (int s = 0; s < 40; s++) begin
      en = 0;
      dwell = DW'($urandom_range(0, 4));
      use_kp = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 1) == 1) for (int r = 0; r < N; r++) kp[r] = ($urandom_range(0, 2) == 0) ? RW'($urandom) : '0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
      en = 1;
      repeat ($urandom_range(20, 300)) begin
        @(negedge clk);
        frame_load = $urandom_range(0, 7) == 0;
        frame_in = $urandom;
        noise = RW'($urandom);
        if ($urandom_range(0, 60) == 0) kp[$urandom_range(0, N-1)] = RW'($urandom);
      end
      frame_load = 0;
    end
    en = 0; use_kp = 1;
    for (int r = 0; r < N; r++) kp[r] = '0;
    repeat (3) @(negedge clk);
    dwell = 5; en = 1;
    repeat (14) @(negedge clk);
    cmp("r_pre_sel", scan_sel, 4'b0100);
    #2 arst_n = 0;
    #1;
    cmp("r_sel", scan_sel, 0);
    cmp("r_seg", seg_out, 0);
    cmp("r_key", key_state, 0);
    cmp("r_done", frame_done, 0);
    en = 0;
    repeat (3) @(negedge clk);
    arst_n = 1;
    repeat (4) @(negedge clk);
    cmp("r_idle_sel", scan_sel, 0);
    en = 1;
    @(negedge clk);
    cmp("r_restart_sel", scan_sel, 4'b0001);
    en = 0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
